float_hist: RTL
===============

# float_hist

Predictor operand history and floating-point formatter for the MCAC adaptive predictor, sitting directly upstream of the floating multiply-accumulate stage. Converts each new quantized difference (DQ, sign-magnitude) and reconstructed signal (SR, two's complement) to the 11-bit G.726 float format. Holds a 6-deep DQ history and a 2-deep SR history. On request, streams all 8 float operands to the multiplier over a valid/ready handshake.

## Interface
- DQ_TAPS, 6, DQ history depth (zero-section taps)
- SR_TAPS, 2, SR history depth (pole-section taps)
- RST_FLOAT, 11'h020, history reset/float-of-zero value (sign 0, exp 0, mant 32)

- clk  input  1  system clock
- reset  input  1  system reset; asynchronous, active-high
- upd  input  1  push new sample into both histories
- dq_in  input  16  DQ; bit 15 sign, [14:0] magnitude
- sr_in  input  16  SR, two's complement
- start  input  1  begin operand stream
- out_valid  output  1  operand valid
- out_ready  input  1  downstream accepts operand
- out_idx  output  3  operand index 0..7
- out_float  output  11  {sign, exp[3:0], mant[5:0]}
- out_last  output  1  high with index 7
- busy  output  1  stream in progress
- upd_err  output  1  sticky: upd seen while busy
- scan_in0  input  1  test scan data in
- scan_en  input  1  test scan enable
- scan_out0  output  1  test scan data out

## Operation
- Float encode of magnitude MAG (15 bits): EXP = 0 if MAG=0, else index of leading one plus 1 (1..15); MANT = 32 if MAG=0, else (MAG<<6)>>EXP (6 bits, MSB set).
- DQ: sign = dq_in[15], MAG = dq_in[14:0].
- SR: sign = sr_in[15]; MAG = sign ? (65536-sr_in) & 16'h7FFF : sr_in[14:0]. The value 0x8000 encodes as 11'h420.
- upd accepted only in IDLE. Both histories shift by one; the new float enters entry 1 and the oldest entry drops.
- upd in STREAM: ignored, upd_err set until reset.
- FSM IDLE -> STREAM on start (in IDLE). start in STREAM is ignored.
- STREAM: out_valid=1, out_float=entry[out_idx]. Order: idx 0..5 = DQ1..DQ6 (newest first), idx 6..7 = SR1..SR2.
- Each out_valid&&out_ready increments idx. Handshake at idx 7 returns the FSM to IDLE with idx 0.
- out_float and out_idx hold stable while out_valid && !out_ready.
- upd and start in the same IDLE cycle: shift happens and the stream carries the updated history.
- busy = (state==STREAM).
- Scan ports: functional behaviour is independent of them. With scan_en=0, scan_out0 drives 0. Chain stitching is done at synthesis.

## Timing
- Reset values: out_valid 0, out_idx 0, out_float 0, out_last 0, busy 0, upd_err 0, scan_out0 0, all history entries RST_FLOAT, FSM IDLE.
- start sampled at edge k: out_valid high from edge k+1.
- With out_ready held high, the stream takes 8 cycles: idx 0 at k+1 through idx 7 at k+8. busy drops at edge k+9.
- Back-to-back: start may be asserted in the first IDLE cycle after the stream.
- reset asserted mid-stream: immediate return to IDLE, histories cleared, no partial resume.
- Conversion is combinational into the history registers; a history write takes effect at the upd edge.

## Configuration
- FLOAT_HIST_PARITY_EN defined: adds output out_par (1 bit) = even parity (XOR) of out_float, valid with out_valid, reset 0.
- FLOAT_HIST_PARITY_EN undefined: no out_par port; all other behaviour identical.

## Test plan
- After reset, start with out_ready=1 -> 8 operands, all 11'h020, idx 0..7, out_last only at idx 7, busy low at cycle 9.
- upd with dq_in=16'h8001, sr_in=16'h7FFF, then start -> idx0 = 11'h460, idx6 = 11'h3FF, other entries 11'h020.
- upd with dq_in=16'h0005, then a second upd with sr_in=16'hFFFF -> idx0 = 11'h020, idx1 = 11'h0E8, idx6 = 11'h460; sr_in=16'h8000 encodes as 11'h420.
- Stream with out_ready toggling 1,0,0,1 -> out_float/out_idx hold during stalls, no index skipped or repeated.
- upd pulsed mid-stream -> history unchanged and upd_err=1; reset asserted at idx 3 -> out_valid 0 immediately, history 11'h020, upd_err 0.
- With FLOAT_HIST_PARITY_EN, operand 11'h460 -> out_par=1 and 11'h020 -> out_par=1.

Source files
------------

// File: rtl/float_hist.sv
// -----------------------------------------------------------------------------
// float_hist
//
// Operand history and float formatter for the MCAC adaptive predictor. It sits
// just ahead of the floating multiply-accumulate stage.
//
// Each accepted update converts two values to the 11-bit G.726 float format
// {sign, exp[3:0], mant[5:0]}:
//   - the quantized difference DQ, in sign-magnitude form
//   - the reconstructed signal SR, in two's complement form
// The converted values are pushed into a DQ_TAPS-deep DQ history and an
// SR_TAPS-deep SR history. On start, all operands are streamed out newest
// first over a valid/ready handshake: DQ1..DQ6 first, then SR1..SR2.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   upd        push dq_in / sr_in into the histories (honoured only in IDLE)
//   dq_in      DQ, bit 15 sign, [14:0] magnitude
//   sr_in      SR, two's complement
//   start      begin an operand stream (honoured only in IDLE)
//   out_valid  operand valid
//   out_ready  downstream accepts the operand
//   out_idx    operand index 0..7
//   out_float  operand in float format (0 when out_valid is low)
//   out_last   high together with the final operand index
//   busy       stream in progress
//   upd_err    sticky flag: upd arrived while streaming; cleared only by reset
//   scan_in0   test scan data in
//   scan_en    test scan enable
//   scan_out0  test scan data out (0 whenever scan_en is low)
//   out_par    even parity (XOR) of out_float; present only with
//              FLOAT_HIST_PARITY_EN
//
// Build option
//   FLOAT_HIST_PARITY_EN  adds the out_par output
// -----------------------------------------------------------------------------
module float_hist #(
    parameter int          DQ_TAPS   = 6,
    parameter int          SR_TAPS   = 2,
    parameter logic [10:0] RST_FLOAT = 11'h020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upd,
    input  logic [15:0] dq_in,
    input  logic [15:0] sr_in,
    input  logic        start,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_idx,
    output logic [10:0] out_float,
    output logic        out_last,
    output logic        busy,
    output logic        upd_err,
    input  logic        scan_in0,
    input  logic        scan_en,
`ifdef FLOAT_HIST_PARITY_EN
    output logic        out_par,
`endif
    output logic        scan_out0
);

    localparam int         NUM_OPS  = DQ_TAPS + SR_TAPS;
    localparam logic [2:0] LAST_IDX = 3'(NUM_OPS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Float encoder.
    // The exponent is the bit position of the leading one plus 1.
    // Shifting the magnitude left by 6 and then right by the exponent leaves
    // the leading one at mantissa bit 5, so the 6-bit mantissa is normalised.
    // A zero magnitude has no leading one; it takes exponent 0 and the
    // canonical mantissa 32.
    // -------------------------------------------------------------------------
    function automatic logic [10:0] float_enc(input logic sgn, input logic [14:0] mag);
        logic [3:0]  e;
        logic [20:0] sh;
        logic [5:0]  m;
        e = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (mag[i]) e = 4'(i + 1);
        end
        sh = {mag, 6'b000000} >> e;
        m  = (mag == 15'd0) ? 6'd32 : sh[5:0];
        return {sgn, e, m};
    endfunction

    // -------------------------------------------------------------------------
    // SR magnitude.
    // A negative SR is negated modulo 2^16 and then truncated to 15 bits.
    // This sends 0x8000 to magnitude 0 with the sign kept, which encodes as
    // 11'h420.
    // -------------------------------------------------------------------------
    function automatic logic [14:0] sr_mag(input logic [15:0] sr);
        logic [15:0] neg;
        neg = 16'(~sr + 16'd1);
        return sr[15] ? neg[14:0] : sr[14:0];
    endfunction

    // Registers
    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        upd_err_q;
    logic [10:0] dq_hist [DQ_TAPS];
    logic [10:0] sr_hist [SR_TAPS];

    // Control strobes from the next-state logic
    logic        hist_we;
    logic        err_set;

    // Combinational conversion of the incoming samples
    logic [10:0] dq_float;
    logic [10:0] sr_float;
    logic [10:0] op_sel;

    assign dq_float = float_enc(dq_in[15], dq_in[14:0]);
    assign sr_float = float_enc(sr_in[15], sr_mag(sr_in));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state, index advance and history/error strobes
    //
    // The history may only shift in IDLE. This keeps every operand of a
    // stream, including stalled ones, stable until the stream is done.
    // An upd that arrives while streaming is dropped and flagged instead.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hist_we = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                hist_we = upd;
                if (start) begin
                    state_d = STREAM;
                    idx_d   = 3'd0;
                end
            end
            STREAM: begin
                err_set = upd;
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sticky update-error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_err_q <= 1'b0;
        end else if (err_set) begin
            upd_err_q <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Histories.
    // Entry 1 is array element 0. On an update the newest float enters
    // element 0 and the oldest element drops off the end.
    // If upd and start fall in the same IDLE cycle, the shift happens at that
    // edge, so the stream that follows reads the updated history.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DQ_TAPS; i++) dq_hist[i] <= RST_FLOAT;
        end else if (hist_we) begin
            dq_hist[0] <= dq_float;
            for (int i = 1; i < DQ_TAPS; i++) dq_hist[i] <= dq_hist[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SR_TAPS; i++) sr_hist[i] <= RST_FLOAT;
        end else if (hist_we) begin
            sr_hist[0] <= sr_float;
            for (int i = 1; i < SR_TAPS; i++) sr_hist[i] <= sr_hist[i-1];
        end
    end

    // -------------------------------------------------------------------------
    // Operand select.
    // Indices below DQ_TAPS read the DQ history; the rest read the SR history.
    // The select is a compare per entry, so an index outside the range yields
    // zero instead of an out-of-bounds access.
    // -------------------------------------------------------------------------
    always_comb begin
        op_sel = 11'd0;
        for (int i = 0; i < DQ_TAPS; i++) begin
            if (idx_q == 3'(i)) op_sel = dq_hist[i];
        end
        for (int j = 0; j < SR_TAPS; j++) begin
            if (idx_q == 3'(DQ_TAPS + j)) op_sel = sr_hist[j];
        end
    end

    // -------------------------------------------------------------------------
    // Outputs.
    // Every output is decoded from registered state, so out_float and out_idx
    // hold while the stream is stalled. out_float is forced to zero outside a
    // stream, so the bus stays quiet when no operand is offered.
    // -------------------------------------------------------------------------
    assign out_valid = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign out_idx   = idx_q;
    assign out_float = out_valid ? op_sel : 11'd0;
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign upd_err   = upd_err_q;

    // Scan output is gated by scan_en; the chain itself is stitched at synthesis.
    assign scan_out0 = scan_en & scan_in0;

`ifdef FLOAT_HIST_PARITY_EN
    assign out_par = ^out_float;
`endif

endmodule
